// File: rtl/halt_pkg.sv
// Shared definitions for the halt controller: FSM state encodings, trap
// cause codes and the ebreak encoding.
package halt_pkg;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_SIGNAL = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_BREAK   = 2'd1,
    CAUSE_UNKNOWN = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/halt_wdog.sv
// Idle watchdog: counts cycles without an issued instruction and flags
// expiry when the count reaches WDOG_CYCLES-1. WDOG_CYCLES of 0 disables it.
module halt_wdog
  import halt_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [31:0] WdogLimit = (WDOG_CYCLES == 0) ? 32'd0 : 32'(WDOG_CYCLES - 1);
  localparam logic        WdogOn    = (WDOG_CYCLES != 0);

  logic [31:0] cnt_q, cnt_d;

  // Saturating count so a very long idle period can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 32'd0;
    end else if (enable_i && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = WdogOn && enable_i && (cnt_q == WdogLimit);

endmodule

// File: rtl/halt_ctrl.sv
// Trap detector in front of the simulation-exit block: freezes the core on
// ebreak, illegal instruction or watchdog timeout, drains, then pulses once.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned CNT_W        = 64,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WDOG_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_valid,
  input  logic [XLEN-1:0]  inst,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  a0,
  input  logic             dec_illegal,
  output logic             halt,
  output logic             is_break_out,
  output logic             is_unknown_instruction,
  output logic [1:0]       halt_cause,
  output logic [XLEN-1:0]  halt_pc,
  output logic [XLEN-1:0]  halt_code,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  localparam logic [31:0]     DrainLoad = 32'(DRAIN_CYCLES - 1);
  localparam logic [XLEN-1:0] Ebreak    = XLEN'(EBREAK_INST);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      drain_q, drain_d;
  logic             halt_q, halt_d;
  logic             brk_q, brk_d;
  logic             unk_q, unk_d;
  cause_e           cause_q, cause_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  code_q, code_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic in_run;
  logic wdog_expired;

  assign in_run = (state_q == ST_RUN);

  halt_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (in_run && inst_valid),
    .enable_i (in_run && !inst_valid),
    .expired_o(wdog_expired)
  );

  // Trap priority in RUN is ebreak, then illegal, then watchdog; a valid
  // instruction always clears the watchdog path for that cycle.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    halt_d    = halt_q;
    brk_d     = 1'b0;
    unk_d     = 1'b0;
    cause_d   = cause_q;
    pc_d      = pc_q;
    code_d    = code_q;
    last_pc_d = last_pc_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;

    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + CntOne;
        if (inst_valid && (inst == Ebreak)) begin
          cause_d   = CAUSE_BREAK;
          pc_d      = pc;
          code_d    = a0;
          instret_d = instret_q + CntOne;
          halt_d    = 1'b1;
          drain_d   = DrainLoad;
          state_d   = ST_DRAIN;
        end else if (inst_valid && dec_illegal) begin
          cause_d = CAUSE_UNKNOWN;
          pc_d    = pc;
          code_d  = inst;
          halt_d  = 1'b1;
          drain_d = DrainLoad;
          state_d = ST_DRAIN;
        end else if (inst_valid) begin
          instret_d = instret_q + CntOne;
          last_pc_d = pc;
        end else if (wdog_expired) begin
          cause_d = CAUSE_TIMEOUT;
          pc_d    = last_pc_q;
          code_d  = '0;
          halt_d  = 1'b1;
          drain_d = DrainLoad;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        cycle_d = cycle_q + CntOne;
        if (drain_q == 32'd0) begin
          brk_d   = (cause_q == CAUSE_BREAK);
          unk_d   = (cause_q != CAUSE_BREAK);
          state_d = ST_SIGNAL;
        end else begin
          drain_d = drain_q - 32'd1;
        end
      end
      ST_SIGNAL: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      drain_q   <= 32'd0;
      halt_q    <= 1'b0;
      brk_q     <= 1'b0;
      unk_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
      pc_q      <= '0;
      code_q    <= '0;
      last_pc_q <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      halt_q    <= halt_d;
      brk_q     <= brk_d;
      unk_q     <= unk_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      code_q    <= code_d;
      last_pc_q <= last_pc_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign halt                   = halt_q;
  assign is_break_out           = brk_q;
  assign is_unknown_instruction = unk_q;
  assign halt_cause             = cause_q;
  assign halt_pc                = pc_q;
  assign halt_code              = code_q;
  assign cycle_cnt              = cycle_q;
  assign instret_cnt            = instret_q;

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: one 64-bit-counter instance with an 8-cycle
// watchdog and one 4-bit-counter instance with the watchdog disabled.
module tb_halt_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI   = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;

  logic        aValid, aIllegal;
  logic [31:0] aInst, aPc, aA0;
  logic        aHalt, aBrk, aUnk;
  logic [1:0]  aCause;
  logic [31:0] aHaltPc, aHaltCode;
  logic [63:0] aCycle, aInstret;

  logic        bValid, bIllegal;
  logic [31:0] bInst, bPc, bA0;
  logic        bHalt, bBrk, bUnk;
  logic [1:0]  bCause;
  logic [31:0] bHaltPc, bHaltCode;
  logic [3:0]  bCycle, bInstret;

  int vectors = 0;
  int miscompares = 0;

  halt_ctrl #(
    .XLEN(32), .CNT_W(64), .DRAIN_CYCLES(2), .WDOG_CYCLES(8)
  ) dutA (
    .clk(clk), .reset(reset),
    .inst_valid(aValid), .inst(aInst), .pc(aPc), .a0(aA0), .dec_illegal(aIllegal),
    .halt(aHalt), .is_break_out(aBrk), .is_unknown_instruction(aUnk),
    .halt_cause(aCause), .halt_pc(aHaltPc), .halt_code(aHaltCode),
    .cycle_cnt(aCycle), .instret_cnt(aInstret)
  );

  halt_ctrl #(
    .XLEN(32), .CNT_W(4), .DRAIN_CYCLES(2), .WDOG_CYCLES(0)
  ) dutB (
    .clk(clk), .reset(reset),
    .inst_valid(bValid), .inst(bInst), .pc(bPc), .a0(bA0), .dec_illegal(bIllegal),
    .halt(bHalt), .is_break_out(bBrk), .is_unknown_instruction(bUnk),
    .halt_cause(bCause), .halt_pc(bHaltPc), .halt_code(bHaltCode),
    .cycle_cnt(bCycle), .instret_cnt(bInstret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] p,
                               input logic [31:0] a, input logic ill);
    aValid = v; aInst = i; aPc = p; aA0 = a; aIllegal = ill;
  endtask

  task automatic applyStimulusB(input logic v, input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] a, input logic ill);
    bValid = v; bInst = i; bPc = p; bA0 = a; bIllegal = ill;
  endtask

  // Holds reset across one edge; released 1 ns after it so the next edge is the first RUN edge.
  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    applyStimulusB(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    resetDut();
    reset = 1'b1;
    #1;
    checkOutput("rst halt", aHalt, 0);
    checkOutput("rst brk", aBrk, 0);
    checkOutput("rst unk", aUnk, 0);
    checkOutput("rst cause", aCause, 0);
    checkOutput("rst pc", aHaltPc, 0);
    checkOutput("rst code", aHaltCode, 0);
    checkOutput("rst cycle", aCycle, 0);
    checkOutput("rst instret", aInstret, 0);
    reset = 1'b0;

    // Five addi then ebreak
    resetDut();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, ADDI, 32'h8000_0000 + 32'(4 * i), 32'(i), 1'b0);
      step();
    end
    checkOutput("t1 halt pre", aHalt, 0);
    checkOutput("t1 instret pre", aInstret, 5);
    applyStimulus(1'b1, EBREAK, 32'h8000_0014, 32'd0, 1'b0);
    step();
    checkOutput("t1 halt", aHalt, 1);
    checkOutput("t1 brk e1", aBrk, 0);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    checkOutput("t1 brk e2", aBrk, 0);
    step();
    checkOutput("t1 brk pulse", aBrk, 1);
    checkOutput("t1 unk", aUnk, 0);
    checkOutput("t1 cause", aCause, 1);
    checkOutput("t1 pc", aHaltPc, 32'h8000_0014);
    checkOutput("t1 code", aHaltCode, 0);
    checkOutput("t1 instret", aInstret, 6);
    checkOutput("t1 cycle", aCycle, 8);
    step();
    checkOutput("t1 brk after", aBrk, 0);
    checkOutput("t1 halt held", aHalt, 1);
    checkOutput("t1 cycle frozen", aCycle, 8);

    // Illegal instruction
    resetDut();
    applyStimulus(1'b1, ADDI, 32'h8000_0000, 32'd0, 1'b0);
    step();
    applyStimulus(1'b1, ADDI, 32'h8000_0004, 32'd0, 1'b0);
    step();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 32'h8000_0008, 32'd9, 1'b1);
    step();
    checkOutput("t2 halt", aHalt, 1);
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    checkOutput("t2 unk pulse", aUnk, 1);
    checkOutput("t2 brk", aBrk, 0);
    checkOutput("t2 cause", aCause, 2);
    checkOutput("t2 pc", aHaltPc, 32'h8000_0008);
    checkOutput("t2 code", aHaltCode, 32'hFFFF_FFFF);
    checkOutput("t2 instret", aInstret, 2);

    // Ebreak with dec_illegal: BREAK wins
    resetDut();
    applyStimulus(1'b1, EBREAK, 32'h8000_0000, 32'h2A, 1'b1);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    checkOutput("t3 unk e2", aUnk, 0);
    step();
    checkOutput("t3 brk pulse", aBrk, 1);
    checkOutput("t3 unk", aUnk, 0);
    checkOutput("t3 cause", aCause, 1);
    checkOutput("t3 code", aHaltCode, 32'h2A);
    step();
    checkOutput("t3 unk after", aUnk, 0);
    checkOutput("t3 brk after", aBrk, 0);

    // Watchdog timeout
    resetDut();
    applyStimulus(1'b1, ADDI, 32'h8000_0000, 32'd0, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 7; i++) step();
    checkOutput("t4 halt at 7", aHalt, 0);
    step();
    checkOutput("t4 halt at 8", aHalt, 1);
    checkOutput("t4 unk early", aUnk, 0);
    step();
    step();
    checkOutput("t4 unk pulse", aUnk, 1);
    checkOutput("t4 cause", aCause, 3);
    checkOutput("t4 pc", aHaltPc, 32'h8000_0000);
    checkOutput("t4 code", aHaltCode, 0);
    checkOutput("t4 instret", aInstret, 1);

    // Reset during DRAIN
    resetDut();
    applyStimulus(1'b1, EBREAK, 32'h8000_0000, 32'd5, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("t5 halt drain", aHalt, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5 async halt", aHalt, 0);
    checkOutput("t5 async cause", aCause, 0);
    checkOutput("t5 async pc", aHaltPc, 0);
    checkOutput("t5 async code", aHaltCode, 0);
    checkOutput("t5 async instret", aInstret, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("t5 no brk", aBrk, 0);
      checkOutput("t5 no unk", aUnk, 0);
    end
    applyStimulus(1'b1, EBREAK, 32'h8000_0040, 32'h77, 1'b0);
    step();
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    checkOutput("t5 brk pulse", aBrk, 1);
    checkOutput("t5 cause", aCause, 1);
    checkOutput("t5 pc", aHaltPc, 32'h8000_0040);
    checkOutput("t5 code", aHaltCode, 32'h77);
    checkOutput("t5 instret", aInstret, 1);

    // 4-bit counter wrap and HALTED stability
    resetDut();
    for (int i = 0; i < 17; i++) begin
      applyStimulusB(1'b1, ADDI, 32'h8000_0000 + 32'(4 * i), 32'd0, 1'b0);
      step();
    end
    checkOutput("t6 instret wrap", bInstret, 1);
    checkOutput("t6 cycle wrap", bCycle, 1);
    applyStimulusB(1'b1, EBREAK, 32'h8000_0100, 32'd3, 1'b0);
    step();
    applyStimulusB(1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    step();
    checkOutput("t6 brk pulse", bBrk, 1);
    checkOutput("t6 instret", bInstret, 2);
    checkOutput("t6 cycle", bCycle, 4);
    step();
    for (int i = 0; i < 20; i++) begin
      applyStimulusB(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 0) ? EBREAK : 32'($urandom),
                     32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
      step();
      checkOutput("t6 halted brk", bBrk, 0);
      checkOutput("t6 halted unk", bUnk, 0);
      checkOutput("t6 halted instret", bInstret, 2);
      checkOutput("t6 halted cycle", bCycle, 4);
      checkOutput("t6 halted halt", bHalt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
